rll_key_unit: RTL and testbench



---
 rtl/rll_key_unit.sv | 135 +++++++++++++
 tb/tb_rll_key_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_unit.sv
// rll_key_unit: loadable key-gate stage for a random-logic-locked core.
// A key is shifted in MSB first over a valid/ready handshake into a shadow
// register. It is committed atomically to the active key, which drives a
// registered bank of XOR/XNOR gates on the core's output data.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   key_in/key_valid      serial key bit and its qualifier
//   key_last              marks the final key bit (sampled with key_valid)
//   key_ready             key bit accepted this cycle (low only in COMMIT)
//   key_clr               synchronous clear of the key path
//   key_loaded            a key has been committed since reset/clear
//   key_err               one-cycle pulse on a framing error
//   in_valid/in_data      data from the locked core
//   out_valid/out_data    registered, key-gated data
module rll_key_unit #(
  parameter int unsigned      KEY_W    = 32,
  parameter int unsigned      DATA_W   = 32,
  parameter logic [KEY_W-1:0] POL_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  input  logic              key_valid,
  input  logic              key_last,
  output logic              key_ready,
  input  logic              key_clr,
  output logic              key_loaded,
  output logic              key_err,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  shadow;
  logic [KEY_W-1:0]  shadow_shifted;
  logic [KEY_W-1:0]  key_eff;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              is_final;

  // Next shadow value and whether the accepted bit would be the KEY_W-th one.
  always_comb begin
    shadow_shifted = {shadow[KEY_W-2:0], key_in};
    cnt_inc        = cnt + CNT_W'(1);
    is_final       = (cnt_inc == CNT_W'(KEY_W));
  end

  // Key-load FSM: clear has priority, then the per-state handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key        <= '0;
      shadow     <= '0;
      cnt        <= '0;
      key_ready  <= 1'b1;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else if (key_clr) begin
      state      <= IDLE;
      key        <= '0;
      shadow     <= '0;
      cnt        <= '0;
      key_ready  <= 1'b1;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      key_err <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          if (key_valid) begin
            if (is_final && key_last) begin
              shadow    <= shadow_shifted;
              cnt       <= cnt_inc;
              state     <= COMMIT;
              key_ready <= 1'b0;
            end else if (is_final || key_last) begin
              // Framing error: drop the partial key, keep the active one.
              shadow  <= '0;
              cnt     <= '0;
              state   <= IDLE;
              key_err <= 1'b1;
            end else begin
              shadow <= shadow_shifted;
              cnt    <= cnt_inc;
              state  <= SHIFT;
            end
          end
        end
        COMMIT: begin
          key        <= shadow;
          key_loaded <= 1'b1;
          cnt        <= '0;
          state      <= IDLE;
          key_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

  // The commit edge already gates with the new key, so there is no
  // cycle of data carrying a stale key after the commit.
  always_comb begin
    key_eff = ((state == COMMIT) && !key_clr) ? shadow : key;
  end

  // Key-gate bank; bits above KEY_W pass through unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data ^ DATA_W'(key_eff ^ POL_MASK);
      end
    end
  end

endmodule

// File: tb/tb_rll_key_unit.sv
module tb_rll_key_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in, key_valid, key_last, key_clr;
  logic       key_ready, key_loaded, key_err;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_key;   // key that applies to data sampled at the next edge
  logic [7:0] last_exp;  // expected held value of out_data

  rll_key_unit #(.KEY_W(8), .DATA_W(8), .POL_MASK(8'hF0)) dut (
    .clk(clk), .rst(rst),
    .key_in(key_in), .key_valid(key_valid), .key_last(key_last),
    .key_ready(key_ready), .key_clr(key_clr),
    .key_loaded(key_loaded), .key_err(key_err),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: push the expected gated value, step, then score the output.
  task automatic tick(input string tag);
    logic       v;
    logic [7:0] e;
    v = in_valid;
    if (in_valid) exp_q.push_back(in_data ^ cur_key ^ 8'hF0);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk({tag, ".out_data"}, 32'(out_data), 32'(e));
      end
    end else begin
      chk({tag, ".hold"}, 32'(out_data), 32'(last_exp));
    end
  endtask

  task automatic bit_step(input logic b, input logic last, input string tag);
    key_valid = 1'b1;
    key_in    = b;
    key_last  = last;
    tick(tag);
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  // Full MSB-first load; key_valid stays high during COMMIT and must be ignored.
  task automatic load_key(input logic [7:0] k, input string tag);
    for (int i = 7; i >= 0; i--) begin
      key_valid = 1'b1;
      key_in    = k[i];
      key_last  = (i == 0);
      tick(tag);
      chk({tag, ".ready"}, 32'(key_ready), (i == 0) ? 32'd0 : 32'd1);
      chk({tag, ".err"},   32'(key_err), 32'd0);
    end
    key_valid = 1'b1;
    key_in    = 1'b1;
    key_last  = 1'b0;
    cur_key   = k;
    tick({tag, ".commit"});
    key_valid = 1'b0;
    chk({tag, ".ready_after"}, 32'(key_ready), 32'd1);
    chk({tag, ".loaded"},      32'(key_loaded), 32'd1);
    chk({tag, ".err_after"},   32'(key_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; key_in = 1'b0; key_valid = 1'b0; key_last = 1'b0; key_clr = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    cur_key = 8'h00; last_exp = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready",     32'(key_ready), 32'd1);
    chk("rst.loaded",    32'(key_loaded), 32'd0);
    chk("rst.err",       32'(key_err), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data), 32'd0);
    rst = 1'b0;

    // No key: 3C -> CC
    tick("nokey");
    chk("nokey.loaded", 32'(key_loaded), 32'd0);
    in_valid = 1'b0;
    tick("nokey_hold");

    // Load A5 with data running across the commit (CC before, 69 after)
    in_valid = 1'b1;
    load_key(8'hA5, "loadA5");
    tick("afterA5");
    in_valid = 1'b0;
    tick("afterA5_idle");

    // key_last on bit 5: error pulse, key unchanged
    bit_step(1'b1, 1'b0, "early1");
    bit_step(1'b0, 1'b0, "early2");
    bit_step(1'b1, 1'b0, "early3");
    bit_step(1'b1, 1'b0, "early4");
    bit_step(1'b0, 1'b1, "early5");
    chk("early.err",    32'(key_err), 32'd1);
    chk("early.ready",  32'(key_ready), 32'd1);
    chk("early.loaded", 32'(key_loaded), 32'd1);
    tick("early_next");
    chk("early.err_pulse", 32'(key_err), 32'd0);
    in_valid = 1'b1;
    tick("early_data");

    // 8 bits without key_last: error after bit 8, no commit
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_step(1'b0, 1'b0, "nolast");
      chk("nolast.err", 32'(key_err), (i == 7) ? 32'd1 : 32'd0);
    end
    tick("nolast_next");
    chk("nolast.err_pulse", 32'(key_err), 32'd0);
    chk("nolast.loaded",    32'(key_loaded), 32'd1);
    in_valid = 1'b1;
    tick("nolast_data");

    // key_clr after a load: back to the unkeyed mapping
    in_valid = 1'b0;
    key_clr  = 1'b1;
    tick("clr");
    key_clr  = 1'b0;
    cur_key  = 8'h00;
    chk("clr.loaded", 32'(key_loaded), 32'd0);
    chk("clr.err",    32'(key_err), 32'd0);
    in_valid = 1'b1;
    tick("clr_data");
    in_valid = 1'b0;

    // key_clr together with the final bit: no commit, no error
    for (int i = 7; i >= 1; i--) bit_step(1'b1, 1'b0, "clrlast");
    key_clr = 1'b1;
    bit_step(1'b1, 1'b1, "clrlast8");
    key_clr = 1'b0;
    chk("clrlast.err",    32'(key_err), 32'd0);
    chk("clrlast.ready",  32'(key_ready), 32'd1);
    tick("clrlast_next");
    chk("clrlast.loaded", 32'(key_loaded), 32'd0);
    chk("clrlast.err2",   32'(key_err), 32'd0);
    in_valid = 1'b1;
    tick("clrlast_data");

    // Reload A5 after errors/clears, then async reset mid-load
    load_key(8'hA5, "reloadA5");
    in_valid = 1'b0;
    tick("reload_idle");
    for (int i = 0; i < 4; i++) bit_step(1'b1, 1'b0, "partial");
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ready",     32'(key_ready), 32'd1);
    chk("arst.loaded",    32'(key_loaded), 32'd0);
    chk("arst.err",       32'(key_err), 32'd0);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data",  32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    chk("arst.out_data2", 32'(out_data), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    cur_key = 8'h00;
    last_exp = 8'h00;

    // Full 5A load after reset: 3C -> 96
    in_valid = 1'b1;
    load_key(8'h5A, "load5A");
    tick("after5A");
    in_valid = 1'b0;
    tick("end");
    chk("end.sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
